// File: rtl/md_unit_pkg.sv
// md_unit shared definitions: op codes, default latencies, decode helpers.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  function automatic logic is_mul(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md(md_op_e op);
    return is_mul(op) || is_div(op);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX-stage to md_unit bundle: forwarded operands in, busy and HI/LO out.
interface md_unit_if;
  import md_unit_pkg::*;

  logic        start;
  md_op_e      md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_data, rt_data,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, rs_data, rt_data,
    output busy, hi, lo
  );

endinterface

// File: rtl/md_unit_calc.sv
// Combinational 64-bit multiply/divide result; we=0 means leave HI/LO alone.
module md_unit_calc
  import md_unit_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        we
);

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic [63:0]        ua;
  logic [63:0]        ub;
  logic [31:0]        bd;
  logic               dz;
  logic               ovf;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0]        uq;
  logic [31:0]        ur;

  assign sa  = {{32{a[31]}}, a};
  assign sb  = {{32{b[31]}}, b};
  assign ua  = {32'd0, a};
  assign ub  = {32'd0, b};
  assign dz  = (b == 32'd0);
  assign ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);

  // min/-1 divides by 1 instead: quotient min, remainder 0, no trap
  assign bd = (dz || ovf) ? 32'd1 : b;
  assign sq = $signed(a) / $signed(bd);
  assign sr = $signed(a) % $signed(bd);
  assign uq = a / bd;
  assign ur = a % bd;

  always_comb begin
    res = 64'd0;
    we  = 1'b0;
    unique case (1'b1)
      op == MD_MULT: begin
        res = sa * sb;
        we  = 1'b1;
      end
      op == MD_MULTU: begin
        res = ua * ub;
        we  = 1'b1;
      end
      op == MD_DIV: begin
        res = {sr, sq};
        we  = !dz;
      end
      op == MD_DIVU: begin
        res = {ur, uq};
        we  = !dz;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e   state;
  md_state_e   state_n;
  logic [CW-1:0] cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] hi_pend;
  logic [31:0] lo_pend;
  logic        pend_we;
  logic [63:0] res;
  logic        res_we;
  logic        accept;
  logic        done;

  md_unit_calc u_calc (
    .op  (md.md_op),
    .a   (md.rs_data),
    .b   (md.rt_data),
    .res (res),
    .we  (res_we)
  );

  assign md.busy = (state == ST_RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        accept = md.start && is_md(md.md_op);
        if (accept) state_n = ST_RUN;
      end
      ST_RUN: begin
        done = (cnt == CW'(1));
        if (done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_pend <= 32'd0;
      lo_pend <= 32'd0;
      pend_we <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (accept) begin
        hi_pend <= res[63:32];
        lo_pend <= res[31:0];
        pend_we <= res_we;
        cnt     <= is_mul(md.md_op) ?
                   CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (md.start) begin
        unique case (1'b1)
          md.md_op == MD_MTHI: hi_q <= md.rs_data;
          md.md_op == MD_MTLO: lo_q <= md.rs_data;
          default: ;
        endcase
      end
    end else if (done) begin
      cnt <= '0;
      if (pend_we) begin
        hi_q <= hi_pend;
        lo_q <= lo_pend;
      end
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic model.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Architectural effect of one op, from plain 64-bit arithmetic
  task automatic model(input md_op_e op, input logic [31:0] a,
                       input logic [31:0] b);
    longint x, y, q, r;
    longint unsigned p;
    case (op)
      MD_MULT: begin
        q = longint'($signed(a)) * longint'($signed(b));
        m_hi = q[63:32];
        m_lo = q[31:0];
      end
      MD_MULTU: begin
        p = longint'(a) * longint'(b);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      MD_DIV: if (b != 0) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        q = x / y;
        r = x % y;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      MD_DIVU: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Entered and left at a negedge; issues at the current cycle
  task automatic run_op(input string tag, input md_op_e op,
                        input logic [31:0] a, input logic [31:0] b);
    int n;
    int exp_n;
    model(op, a, b);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.rs_data = a;
    bus.rt_data = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = MD_NOP;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    exp_n = is_mul(op) ? MC : (is_div(op) ? DC : 0);
    chk({tag, ".busy_len"}, n, exp_n);
    chk({tag, ".hi"}, bus.hi, m_hi);
    chk({tag, ".lo"}, bus.lo, m_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hffff_ffff;
      2: return 32'd0;
      3: return 32'(int'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    md_op_e op;
    logic [31:0] a, b;
    bus.start = 1'b0;
    bus.md_op = MD_NOP;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.hi", bus.hi, 32'd0);
    chk("rst.lo", bus.lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mult", MD_MULT, 32'hffff_fffe, 32'd3);
    chk("mult.hi_c", bus.hi, 32'hffff_ffff);
    chk("mult.lo_c", bus.lo, 32'hffff_fffa);
    run_op("multu", MD_MULTU, 32'hffff_fffe, 32'd3);
    chk("multu.hi_c", bus.hi, 32'h0000_0002);
    run_op("div", MD_DIV, 32'hffff_fff9, 32'd2);
    chk("div.lo_c", bus.lo, 32'hffff_fffd);
    chk("div.hi_c", bus.hi, 32'hffff_ffff);
    run_op("divu", MD_DIVU, 32'd7, 32'd2);
    run_op("mthi", MD_MTHI, 32'h1234_5678, 32'd0);
    run_op("mtlo", MD_MTLO, 32'h0000_00aa, 32'd0);
    run_op("divz", MD_DIVU, 32'hdead_beef, 32'd0);
    chk("divz.hi_c", bus.hi, 32'h1234_5678);
    run_op("ovf", MD_DIV, 32'h8000_0000, 32'hffff_ffff);
    chk("ovf.lo_c", bus.lo, 32'h8000_0000);
    run_op("nop", MD_NOP, 32'h5555_5555, 32'd1);

    // start while busy is ignored, whatever the op
    model(MD_MULT, 32'd1000, 32'd7);
    bus.start = 1'b1;
    bus.md_op = MD_MULT;
    bus.rs_data = 32'd1000;
    bus.rt_data = 32'd7;
    @(negedge clk);
    bus.md_op = MD_MTLO;
    bus.rs_data = 32'h55;
    @(negedge clk);
    bus.md_op = MD_MULT;
    bus.rs_data = 32'd3;
    bus.rt_data = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = MD_NOP;
    n = 2;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("ign.busy_len", n, MC);
    chk("ign.hi", bus.hi, m_hi);
    chk("ign.lo", bus.lo, m_lo);
    // issued on the very cycle busy is low: no dead cycle
    run_op("b2b", MD_MULT, 32'hffff_0001, 32'h0000_ffff);

    // async reset in the middle of a divide
    bus.start = 1'b1;
    bus.md_op = MD_DIVU;
    bus.rs_data = 32'd100;
    bus.rt_data = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = MD_NOP;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst.busy", 32'(bus.busy), 32'd0);
    chk("arst.hi", bus.hi, 32'd0);
    chk("arst.lo", bus.lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (DC + 2) @(negedge clk);
    chk("arst.late_busy", 32'(bus.busy), 32'd0);
    chk("arst.late_hi", bus.hi, 32'd0);
    chk("arst.late_lo", bus.lo, 32'd0);

    for (int i = 0; i < 60; i++) begin
      op = md_op_e'($urandom_range(0, 6));
      a = pick();
      b = pick();
      run_op("rnd", op, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
